// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mips_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_L = 2'b01,
    BUSY_H = 2'b10
  } state_t;

  localparam logic SEL_L = 1'b0;
  localparam logic SEL_H = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/completion bundle between the pipeline requesters, memory and the arbiter.
interface mem_port_arbiter_if;

  logic req_l;
  logic req_h;
  logic mem_ack;
  logic sel;
  logic mem_req;
  logic gnt_l;
  logic gnt_h;
  logic done_l;
  logic done_h;
  logic err_l;
  logic err_h;

  // master: the arbiter itself; slave: the requesters plus memory around it
  modport master (
    input  req_l, req_h, mem_ack,
    output sel, mem_req, gnt_l, gnt_h, done_l, done_h, err_l, err_h
  );

  modport slave (
    output req_l, req_h, mem_ack,
    input  sel, mem_req, gnt_l, gnt_h, done_l, done_h, err_l, err_h
  );

endinterface

// File: rtl/arb_watchdog.sv
// Busy-cycle counter; expired flags the last cycle an access may wait for mem_ack.
module arb_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port (L = fetch, H = load/store).
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed priority to H.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);

  state_t state, next_state;
  logic   sel_q, sel_d;
  logic   last_grant_q, last_grant_d;
  logic   tie_sel;
  logic   busy;
  logic   finish;
  logic   expired;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_sel = ~last_grant_q;
`else
  assign tie_sel = SEL_H;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel_q        <= SEL_L;
      last_grant_q <= SEL_H;
    end else begin
      state        <= next_state;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    unique case (state)
      IDLE: begin
        // sel moves only here, so the external muxes never switch under an active access
        if (bus.req_l || bus.req_h) begin
          if (bus.req_l && bus.req_h) sel_d = tie_sel;
          else                        sel_d = bus.req_h ? SEL_H : SEL_L;
          next_state = (sel_d == SEL_H) ? BUSY_H : BUSY_L;
        end
      end
      BUSY_L, BUSY_H: begin
        if (bus.mem_ack || expired) begin
          next_state   = IDLE;
          last_grant_d = (state == BUSY_H) ? SEL_H : SEL_L;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy   = (state == BUSY_L) || (state == BUSY_H);
  assign finish = busy && (bus.mem_ack || expired);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (finish),
    .en      (busy),
    .expired (expired)
  );

  // Pulses are masked while reset is asserted so an aborted access never reports completion.
  always_comb begin
    bus.sel     = sel_q;
    bus.mem_req = busy;
    bus.gnt_l   = (state == BUSY_L);
    bus.gnt_h   = (state == BUSY_H);
    bus.done_l  = 1'b0;
    bus.done_h  = 1'b0;
    bus.err_l   = 1'b0;
    bus.err_h   = 1'b0;
    if (rst_n) begin
      bus.done_l = (state == BUSY_L) && bus.mem_ack;
      bus.done_h = (state == BUSY_H) && bus.mem_ack;
      bus.err_l  = (state == BUSY_L) && !bus.mem_ack && expired;
      bus.err_h  = (state == BUSY_H) && !bus.mem_ack && expired;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts owner, outcome and length.
module tb_mem_port_arbiter;

  localparam int T = 4;

  typedef struct packed {
    logic       owner;   // 0 = L, 1 = H
    logic       is_err;
    logic [7:0] len;     // busy cycles including the final one
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic model_last = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic pick(input bit l, input bit h);
    if (l && h) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return ~model_last;
`else
      return 1'b1;
`endif
    end
    return h;
  endfunction

  // Ack on busy cycle d (1..T) completes; anything else times out after T cycles.
  task automatic push_txn(input logic w, input int d);
    exp_t e;
    e.owner  = w;
    e.is_err = !(d >= 1 && d <= T);
    e.len    = e.is_err ? 8'(T) : 8'(d);
    exp_q.push_back(e);
    model_last = w;
  endtask

  task automatic set_req(input logic w, input logic v);
    if (w) bus.req_h = v;
    else   bus.req_l = v;
  endtask

  // Entered at posedge+1 of an idle cycle with the request already raised.
  task automatic busy_phase(input logic w, input int d, input bit viol);
    int kend;
    kend = (d >= 1 && d <= T) ? d : T;
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      bus.mem_ack = (k == d);
      if (viol && k == 2) set_req(w, 1'b0);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    set_req(w, 1'b0);
  endtask

  task automatic episode(input int pat);
    bit   l, h, viol;
    logic w;
    int   d, gap;
    l = pat[0];
    h = pat[1];
    bus.req_l   = l;
    bus.req_h   = h;
    bus.mem_ack = 1'($urandom_range(0, 1));
    w    = pick(l, h);
    d    = $urandom_range(0, T + 2);
    viol = !(l && h) && ($urandom_range(0, 3) == 0);
    push_txn(w, d);
    busy_phase(w, d, viol);
    if (l && h) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      d = $urandom_range(0, T + 2);
      push_txn(~w, d);
      busy_phase(~w, d, 1'b0);
    end
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on every done/err pulse.
  logic [7:0] busy_len = '0;
  logic       prev_mem_req = 1'b0;
  logic       prev_sel = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_len     = '0;
      prev_mem_req = 1'b0;
    end else begin
      exp_t e;
      logic owner_act, err_act;
      busy_len = bus.mem_req ? busy_len + 8'd1 : 8'd0;
      check("gnt_decode", {30'd0, bus.gnt_l, bus.gnt_h},
            {30'd0, bus.mem_req && !bus.sel, bus.mem_req && bus.sel});
      if (prev_mem_req && bus.mem_req) check("sel_stable", 32'(bus.sel), 32'(prev_sel));
      if (bus.done_l || bus.done_h || bus.err_l || bus.err_h) begin
        owner_act = bus.done_h || bus.err_h;
        err_act   = bus.err_l || bus.err_h;
        check("one_pulse", $countones({bus.done_l, bus.done_h, bus.err_l, bus.err_h}), 1);
        if (exp_q.size() == 0) begin
          check("spurious_pulse", {owner_act, err_act, busy_len}, 32'h3ff);
        end else begin
          e = exp_q.pop_front();
          check("txn_owner_err_len", {owner_act, err_act, busy_len}, 32'(e));
          check("sel_at_end", 32'(bus.sel), 32'(e.owner));
        end
      end
      prev_mem_req = bus.mem_req;
      prev_sel     = bus.sel;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n       = 1'b0;
    bus.req_l   = 1'b1;
    bus.req_h   = 1'b1;
    bus.mem_ack = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {24'd0, bus.sel, bus.mem_req, bus.gnt_l, bus.gnt_h,
                               bus.done_l, bus.done_h, bus.err_l, bus.err_h}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie straight out of reset, then three more ties.
    for (int i = 0; i < 4; i++) episode(3);

    for (int i = 0; i < 150; i++) episode($urandom_range(1, 3));

    // Reset in the middle of an L access, with an ack arriving in the same cycle.
    bus.req_l = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n       = 1'b0;
    bus.mem_ack = 1'b1;
    bus.req_l   = 1'b0;
    @(negedge clk);
    check("midreset_no_pulse", {30'd0, bus.done_l, bus.err_l}, 32'd0);
    @(posedge clk); #1;
    check("midreset_idle", {30'd0, bus.mem_req, bus.gnt_l}, 32'd0);
    bus.mem_ack = 1'b0;
    model_last  = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) episode($urandom_range(1, 3));
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
